// File: rtl/bcd_pkg.sv
// Shared definitions for the iterative double-dabble binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_e;

    // Decimal digits needed for the largest magnitude the input can carry.
    function automatic int unsigned min_bcd_digits(input int unsigned width,
                                                   input bit          signed_mode);
        longint unsigned max_val;
        int unsigned     n;
        if (signed_mode) begin
            max_val = 64'd1 << (width - 1);
        end else begin
            max_val = (64'd1 << width) - 64'd1;
        end
        n = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule

// File: rtl/binary_to_bcd_converter_param.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, with ready/done handshake.
// Signed inputs are converted as sign + magnitude.
module binary_to_bcd_converter_param
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_WIDTH   = 8,
    parameter int unsigned DIGITS      = 3,
    parameter bit          SIGNED_MODE = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_conversion,
    input  logic [BIN_WIDTH-1:0]          binary_data,
    output logic                          ready,
    output logic                          end_of_conversion,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_data,
    output logic                          bcd_sign
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_WIDTH;
    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

    if (BIN_WIDTH < 2 || BIN_WIDTH > 32) begin : g_bad_width
        $error("BIN_WIDTH must lie in 2..32");
    end
    if (DIGITS < min_bcd_digits(BIN_WIDTH, SIGNED_MODE)) begin : g_bad_digits
        $error("DIGITS too small for BIN_WIDTH/SIGNED_MODE");
    end

    bcd_state_e         r_state;
    logic [SR_W-1:0]    r_shift;
    logic [CNT_W-1:0]   r_count;
    logic               r_sign;
    logic               r_ready;
    logic               r_eoc;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_bcd_sign;

    logic [BCD_W-1:0]     w_adj_bcd;
    logic [SR_W-1:0]      w_adj_full;
    logic                 w_is_neg;
    logic [BIN_WIDTH-1:0] w_magnitude;
    logic                 w_accept;
    logic                 w_last;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .i_digit (r_shift[BIN_WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj_bcd[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign w_adj_full  = {w_adj_bcd, r_shift[BIN_WIDTH-1:0]};
    assign w_is_neg    = SIGNED_MODE && binary_data[BIN_WIDTH-1];
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign w_magnitude = w_is_neg ? (BIN_WIDTH'(0) - binary_data) : binary_data;
    assign w_accept    = start_conversion && (r_state != SHIFT);
    assign w_last      = (r_count == CNT_W'(BIN_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_count    <= '0;
            r_sign     <= 1'b0;
            r_ready    <= 1'b1;
            r_eoc      <= 1'b0;
            r_bcd      <= '0;
            r_bcd_sign <= 1'b0;
        end else begin
            r_eoc <= 1'b0;
            unique case (r_state)
                IDLE: ;
                SHIFT: begin
                    r_shift <= w_adj_full << 1;
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                    end
                end
                DONE: begin
                    r_bcd      <= r_shift[SR_W-1 -: BCD_W];
                    r_bcd_sign <= r_sign;
                    r_eoc      <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            // A start taken in DONE overrides the return to IDLE (back-to-back).
            if (w_accept) begin
                r_shift <= {{BCD_W{1'b0}}, w_magnitude};
                r_sign  <= w_is_neg;
                r_count <= '0;
                r_ready <= 1'b0;
                r_state <= SHIFT;
            end
        end
    end

    assign ready             = r_ready;
    assign end_of_conversion = r_eoc;
    assign bcd_data          = r_bcd;
    assign bcd_sign          = r_bcd_sign;

endmodule

// File: tb/tb_binary_to_bcd_converter_param.sv
// Directed bench for binary_to_bcd_converter_param: default, signed and 16-bit instances.
module tb_binary_to_bcd_converter_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        st0, st1, st2;
    logic [7:0]  d0, d1;
    logic [15:0] d2;
    logic        rdy0, rdy1, rdy2;
    logic        eoc0, eoc1, eoc2;
    logic [11:0] bcd0, bcd1;
    logic [19:0] bcd2;
    logic        sg0, sg1, sg2;

    int n_checks = 0;
    int n_errors = 0;
    int pulses0  = 0;

    binary_to_bcd_converter_param #(.BIN_WIDTH(8), .DIGITS(3), .SIGNED_MODE(1'b0)) u_dut (
        .clk (clk), .reset (reset), .start_conversion (st0), .binary_data (d0),
        .ready (rdy0), .end_of_conversion (eoc0), .bcd_data (bcd0), .bcd_sign (sg0)
    );

    binary_to_bcd_converter_param #(.BIN_WIDTH(8), .DIGITS(3), .SIGNED_MODE(1'b1)) u_dut_s (
        .clk (clk), .reset (reset), .start_conversion (st1), .binary_data (d1),
        .ready (rdy1), .end_of_conversion (eoc1), .bcd_data (bcd1), .bcd_sign (sg1)
    );

    binary_to_bcd_converter_param #(.BIN_WIDTH(16), .DIGITS(5), .SIGNED_MODE(1'b0)) u_dut_w (
        .clk (clk), .reset (reset), .start_conversion (st2), .binary_data (d2),
        .ready (rdy2), .end_of_conversion (eoc2), .bcd_data (bcd2), .bcd_sign (sg2)
    );

    always @(negedge clk) begin
        if (eoc0 === 1'b1) pulses0 <= pulses0 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Start one conversion on instance sel and report the edge (relative to the
    // start edge) at which end_of_conversion is first seen; 0 if never seen.
    task automatic convert(input int sel, input logic [15:0] val, output int lat,
                           output logic [19:0] bcd, output logic sgn);
        logic e;
        @(posedge clk); #1;
        case (sel)
            0:       begin st0 = 1'b1; d0 = val[7:0]; end
            1:       begin st1 = 1'b1; d1 = val[7:0]; end
            default: begin st2 = 1'b1; d2 = val;      end
        endcase
        @(posedge clk); #1;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        lat = 0; bcd = '0; sgn = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            case (sel)
                0:       begin e = eoc0; bcd = {8'h0, bcd0}; sgn = sg0; end
                1:       begin e = eoc1; bcd = {8'h0, bcd1}; sgn = sg1; end
                default: begin e = eoc2; bcd = bcd2;         sgn = sg2; end
            endcase
            if (e === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          p;
        int          first;
        logic [19:0] bcd;
        logic        sgn;

        reset = 1'b1;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", rdy0, 1);
        check("rst_eoc", eoc0, 0);
        check("rst_bcd", bcd0, 0);
        check("rst_sign", sg0, 0);
        reset = 1'b0;

        convert(0, 16'd255, lat, bcd, sgn);
        check("u255_lat", lat, 9);
        check("u255_bcd", bcd, 20'h00255);
        check("u255_sign", sgn, 0);
        check("u255_ready", rdy0, 1);
        @(posedge clk); #1;
        check("u255_eoc_single", eoc0, 0);
        check("u255_hold", bcd0, 12'h255);

        p = pulses0;
        for (int v = 0; v < 256; v++) begin
            convert(0, 16'(v), lat, bcd, sgn);
            check($sformatf("sweep_bcd_%0d", v), bcd, to_bcd(v));
            check($sformatf("sweep_lat_%0d", v), lat, 9);
        end
        @(posedge clk); #1;
        check("sweep_pulses", pulses0 - p, 256);

        // Back-to-back: start held high across both accepting edges.
        @(posedge clk); #1;
        p = pulses0;
        st0 = 1'b1; d0 = 8'd15;
        @(posedge clk); #1;
        d0 = 8'd128;
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk); #1;
            if (i == 9) begin
                check("b2b_eoc1", eoc0, 1);
                check("b2b_bcd1", bcd0, 12'h015);
                check("b2b_busy", rdy0, 0);
                st0 = 1'b0;
            end
            if (i == 18) begin
                check("b2b_eoc2", eoc0, 1);
                check("b2b_bcd2", bcd0, 12'h128);
            end
        end
        @(posedge clk); #1;
        check("b2b_pulses", pulses0 - p, 2);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_hold", bcd0, 12'h128);

        // Second start mid-conversion must be ignored.
        p = pulses0;
        first = 0;
        st0 = 1'b1; d0 = 8'd42;
        @(posedge clk); #1;
        st0 = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin st0 = 1'b1; d0 = 8'd7; end
            if (i == 4) st0 = 1'b0;
            if (eoc0 === 1'b1 && first == 0) begin
                first = i;
                check("mid_bcd", bcd0, 12'h042);
            end
        end
        check("mid_lat", first, 9);
        check("mid_pulses", pulses0 - p, 1);

        // Reset at the fourth shift edge abandons the conversion.
        st0 = 1'b1; d0 = 8'd200;
        @(posedge clk); #1;
        st0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rmid_bcd", bcd0, 0);
        check("rmid_ready", rdy0, 1);
        check("rmid_eoc", eoc0, 0);
        reset = 1'b0;
        p = pulses0;
        repeat (15) @(posedge clk);
        #1;
        check("rmid_no_pulse", pulses0 - p, 0);

        convert(1, 16'h0080, lat, bcd, sgn);
        check("s_m128_lat", lat, 9);
        check("s_m128_bcd", bcd, 20'h00128);
        check("s_m128_sign", sgn, 1);
        convert(1, 16'h00FF, lat, bcd, sgn);
        check("s_m1_bcd", bcd, 20'h00001);
        check("s_m1_sign", sgn, 1);
        convert(1, 16'h007F, lat, bcd, sgn);
        check("s_p127_bcd", bcd, 20'h00127);
        check("s_p127_sign", sgn, 0);
        convert(1, 16'h009C, lat, bcd, sgn);
        check("s_m100_bcd", bcd, 20'h00100);
        check("s_m100_sign", sgn, 1);
        convert(1, 16'h0000, lat, bcd, sgn);
        check("s_zero_bcd", bcd, 20'h00000);
        check("s_zero_sign", sgn, 0);

        convert(2, 16'd65535, lat, bcd, sgn);
        check("w_65535_lat", lat, 17);
        check("w_65535_bcd", bcd, 20'h65535);
        check("w_65535_sign", sgn, 0);
        convert(2, 16'd12345, lat, bcd, sgn);
        check("w_12345_bcd", bcd, 20'h12345);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
